// File: rtl/pwm_peripheral.sv
// Sixteen user outputs: forced low, static high, or one shared 8-bit PWM waveform.
// Duty is shadowed at period boundaries so mid-period writes never produce runt pulses.
module pwm_peripheral #(
   parameter int unsigned CLK_DIV = 13
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  en_reg_out_7_0,
   input  logic [7:0]  en_reg_out_15_8,
   input  logic [7:0]  en_reg_pwm_7_0,
   input  logic [7:0]  en_reg_pwm_15_8,
   input  logic [7:0]  pwm_duty_cycle,
   output logic [15:0] out,
   output logic        period_start
);

   localparam logic [7:0] PRESC_MAX = 8'(CLK_DIV - 1);

   logic [7:0]  presc_q, presc_d;
   logic [7:0]  pwm_cnt_q, pwm_cnt_d;
   logic [7:0]  duty_sh_q, duty_sh_d;
   logic [15:0] out_q, out_d;
   logic        period_start_q, period_start_d;

   logic        tick;
   logic        boundary;
   logic        pwm_sig;
   logic [15:0] en_out;
   logic [15:0] en_pwm;

   assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
   assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

   // With CLK_DIV = 1 PRESC_MAX is 0, so the prescaler stays 0 and ticks every cycle.
   always_comb begin
      tick           = (presc_q == PRESC_MAX);
      boundary       = (presc_q == 8'd0) && (pwm_cnt_q == 8'd0);
      presc_d        = tick ? 8'd0 : presc_q + 8'd1;
      pwm_cnt_d      = tick ? pwm_cnt_q + 8'd1 : pwm_cnt_q;
      duty_sh_d      = boundary ? pwm_duty_cycle : duty_sh_q;
      period_start_d = boundary;
      pwm_sig        = (duty_sh_q == 8'hFF) ? 1'b1 : (pwm_cnt_q < duty_sh_q);
   end

   // Enable has priority over mode: a PWM-selected bit without its enable stays low.
   for (genvar gi = 0; gi < 16; gi++) begin : g_out
      assign out_d[gi] = en_out[gi] & (~en_pwm[gi] | pwm_sig);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_q        <= 8'd0;
         pwm_cnt_q      <= 8'd0;
         duty_sh_q      <= 8'd0;
         out_q          <= 16'h0000;
         period_start_q <= 1'b0;
      end else begin
         presc_q        <= presc_d;
         pwm_cnt_q      <= pwm_cnt_d;
         duty_sh_q      <= duty_sh_d;
         out_q          <= out_d;
         period_start_q <= period_start_d;
      end
   end

   assign out          = out_q;
   assign period_start = period_start_q;

endmodule

// File: doc/pwm_peripheral.md
# pwm_peripheral

Drives the 16 user outputs from the register file written by the SPI peripheral, downstream of it. Each output is either forced low, held static high, or driven by one shared 8-bit PWM waveform whose duty cycle comes from the duty register. A prescaler derives the PWM tick from the system clock, giving roughly 3 kHz at 10 MHz with the default divider. Duty updates are double-buffered at period boundaries so a mid-period register write never produces a runt pulse.

## Interface

**Parameters**
- `CLK_DIV`, default 13: system clocks per PWM counter step; legal range 1..255.

**Ports**
- `clk`  in  1: system clock; single clock domain.
- `rst_n`  in  1: reset; asynchronous, active-low.
- `en_reg_out_7_0`  in  8: output enable, bits 7..0.
- `en_reg_out_15_8`  in  8: output enable, bits 15..8.
- `en_reg_pwm_7_0`  in  8: PWM mode select, bits 7..0.
- `en_reg_pwm_15_8`  in  8: PWM mode select, bits 15..8.
- `pwm_duty_cycle`  in  8: requested duty, 0..255.
- `out`  out  16: registered user outputs.
- `period_start`  out  1: one-cycle pulse marking each PWM period boundary.

All register inputs are synchronous to `clk`; they are not re-synchronised here.

## Operation

**State**
- `presc` (8 b): counts 0..CLK_DIV-1, then wraps to 0.
- `pwm_cnt` (8 b): increments, with natural wrap 255→0, on every edge where `presc == CLK_DIV-1`.
- `duty_sh` (8 b): shadow copy of the duty register.
- If CLK_DIV = 1, `presc` stays 0 and `pwm_cnt` increments every cycle.

**Boundary condition**
- A boundary is any edge where `presc == 0 && pwm_cnt == 0` (pre-edge values).
- At a boundary, `duty_sh <= pwm_duty_cycle` and `period_start <= 1`.
- On every other edge, `period_start <= 0`.

**Waveform** (combinational on pre-edge state)
- `pwm_sig = (duty_sh == 8'hFF) ? 1 : (pwm_cnt < duty_sh)`.
- Duty 0: always low.
- Duty 255: always high, with no one-step low gap.

**Output mapping**, for i in 0..15, with `en_out = {en_reg_out_15_8, en_reg_out_7_0}` and `en_pwm` formed the same way:
- `out[i] <= en_out[i] ? (en_pwm[i] ? pwm_sig : 1) : 0`.
- Output enable has priority: a PWM bit set without its enable gives 0.

**Reset values**
- `presc`, `pwm_cnt`, `duty_sh`: 0.
- `out`: 16'h0000.
- `period_start`: 0.
- Reset is asynchronous: asserting `rst_n` mid-period clears everything immediately.
- After release, the first edge is a boundary.

## Timing

- Period: 256 × CLK_DIV clocks. With the default, 3328 clocks, which is 3.005 kHz at 10 MHz.
- High time: `duty_sh` × CLK_DIV clocks for duty < 255; the whole period for duty 255.
- Enable or mode change to `out`: 1 clock.
- Duty write to effect:
  - The new value is captured at the next boundary edge.
  - The first `out` reflecting it appears 1 clock later.
  - A write mid-period has no effect on the current period.
- `out` high phase begins 1 clock after the boundary edge. `period_start` is high during that same clock.
- After reset release:
  - Edge 1 is a boundary that loads `duty_sh` and sets `period_start`.
  - Edge 2 drives `out` from `pwm_cnt = 0` and the loaded duty.
- Duty written on the same edge as a boundary: the pre-edge `pwm_duty_cycle` value is captured.
- Enables change mid-period: takes effect next clock with no period alignment. Only duty is double-buffered.
- No handshake: inputs are level-sampled every clock.

## Test plan

- **Reset:** assert `rst_n` = 0 with all enables 0xFF and duty 0x80 → `out` = 0x0000 and `period_start` = 0 while in reset. After release, `period_start` pulses on edge 1 and every 3328 clocks thereafter.
- **50 % duty:** `en_reg_out_7_0` = 0x01, `en_reg_pwm_7_0` = 0x01, duty 0x80 → `out[0]` high for 1664 clocks, low for 1664, period 3328; `out[15:1]` = 0.
- **Extremes:** duty 0x00 → `out[0]` constantly 0. Duty 0xFF → `out[0]` constantly 1 across three periods. Duty 0x01 → high for exactly 13 clocks per period.
- **Mode mix:** `en_out` = 0xFFFF, `en_pwm` = 0x00F0, duty 0x40 → bits 4..7 PWM at 832 high / 2496 low; all other bits static 1. Then `en_out` = 0x0000 with `en_pwm` unchanged → `out` = 0 one clock later.
- **Glitch-free update:** change duty 0x80 → 0x20 at clock 500 of a period → current period keeps 1664 high clocks; the next period shows 416 high clocks, starting 1 clock after `period_start`.
- **Reset mid-operation:** assert `rst_n` at clock 1000 of a period with `out[0]` high → `out` drops to 0 asynchronously. After release, the counters restart from 0 and the first full period is 3328 clocks.
